llc_req_sequencer: RTL and testbench

- Sequences the last-level cache (8-way, 16384 sets, MESI) for one trace command at a time: tag lookup, victim writeback, bus operation, state/PLRU update, snoop response.
- Sits between the trace-command front end and the cache array / system-bus model.
- Owns the MESI transitions. The cache array is a pure storage slave that does lookups and writes.
- Also sequences command 8 (clear) as a set-by-set sweep.

---
 rtl/llc_req_sequencer_if.sv | 72 +++++++
 rtl/llc_req_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_llc_req_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llc_req_sequencer_if.sv
// Handshake bundle between the LLC request sequencer and its neighbours:
// trace front end, cache array (lookup/update/clear), system bus and snoop reply.
interface llc_req_sequencer_if #(
   parameter int SETS       = 16384,
   parameter int WAYS       = 8,
   parameter int LINE_BYTES = 64
);
   localparam int INDEX_W = $clog2(SETS);
   localparam int WAY_W   = $clog2(WAYS);
   localparam int OFF_W   = $clog2(LINE_BYTES);
   localparam int TAG_W   = 32 - INDEX_W - OFF_W;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [3:0]         cmd_n;
   logic [31:0]        cmd_addr;
   logic               cmd_done;

   logic               lk_req;
   logic [INDEX_W-1:0] lk_set;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;
   logic [WAY_W-1:0]   lk_way;
   logic [1:0]         lk_state;
   logic [WAY_W-1:0]   lk_vway;
   logic [1:0]         lk_vstate;
   logic [TAG_W-1:0]   lk_vtag;

   logic               upd_valid;
   logic [INDEX_W-1:0] upd_set;
   logic [WAY_W-1:0]   upd_way;
   logic [TAG_W-1:0]   upd_tag;
   logic [1:0]         upd_state;
   logic               upd_touch;

   logic               clr_valid;
   logic [INDEX_W-1:0] clr_set;

   logic               bus_valid;
   logic [1:0]         bus_op;
   logic [31:0]        bus_addr;
   logic               bus_done;
   logic [1:0]         bus_snoop;

   logic               snp_valid;
   logic [1:0]         snp_result;

   // master is the sequencer's view
   modport master (
      input  cmd_valid, cmd_n, cmd_addr,
      input  lk_hit, lk_way, lk_state, lk_vway, lk_vstate, lk_vtag,
      input  bus_done, bus_snoop,
      output cmd_ready, cmd_done,
      output lk_req, lk_set, lk_tag,
      output upd_valid, upd_set, upd_way, upd_tag, upd_state, upd_touch,
      output clr_valid, clr_set,
      output bus_valid, bus_op, bus_addr,
      output snp_valid, snp_result
   );

   modport slave (
      output cmd_valid, cmd_n, cmd_addr,
      output lk_hit, lk_way, lk_state, lk_vway, lk_vstate, lk_vtag,
      output bus_done, bus_snoop,
      input  cmd_ready, cmd_done,
      input  lk_req, lk_set, lk_tag,
      input  upd_valid, upd_set, upd_way, upd_tag, upd_state, upd_touch,
      input  clr_valid, clr_set,
      input  bus_valid, bus_op, bus_addr,
      input  snp_valid, snp_result
   );
endinterface

// File: rtl/llc_req_sequencer.sv
// One-command-at-a-time LLC sequencer: lookup, victim writeback, bus op,
// MESI/PLRU update, snoop reply, and the set-by-set clear sweep.
module llc_req_sequencer #(
   parameter int SETS       = 16384,
   parameter int WAYS       = 8,
   parameter int LINE_BYTES = 64
) (
   input  logic                clk,
   input  logic                rst,
   llc_req_sequencer_if.master bus_if
);
   localparam int INDEX_W = $clog2(SETS);
   localparam int WAY_W   = $clog2(WAYS);
   localparam int OFF_W   = $clog2(LINE_BYTES);
   localparam int TAG_W   = 32 - INDEX_W - OFF_W;

   localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_EVAL = 3'd2, S_EVICT = 3'd3,
                          S_BUS = 3'd4, S_UPDATE = 3'd5, S_CLEAR = 3'd6, S_DONE = 3'd7;
   localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
   localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVAL = 2'd2, OP_RWIM = 2'd3;
   localparam logic [1:0] SN_NOHIT = 2'd0, SN_HIT = 2'd1, SN_HITM = 2'd2;
   localparam logic [3:0] C_RD = 4'd0, C_WR = 4'd1, C_IF = 4'd2, C_SRD = 4'd3,
                          C_SRWIM = 4'd5, C_SINV = 4'd6, C_CLR = 4'd8;

   logic [2:0]         state_q, state_d;
   logic [3:0]         cmd_q, cmd_d;
   logic [INDEX_W-1:0] set_q, set_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [TAG_W-1:0]   vtag_q, vtag_d;
   logic [WAY_W-1:0]   way_q, way_d;
   logic [1:0]         ustate_q, ustate_d;
   logic               touch_q, touch_d;
   logic [1:0]         op_q, op_d;
   logic [INDEX_W-1:0] clr_q, clr_d;
   logic               snp_valid_c;
   logic [1:0]         snp_res_c;
   logic               resident;
   logic               unused_offset;

   assign unused_offset = ^bus_if.cmd_addr[OFF_W-1:0];
   // a hit on an invalid line is treated exactly like a miss
   assign resident = bus_if.lk_hit && (bus_if.lk_state != ST_I);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      set_d       = set_q;
      tag_d       = tag_q;
      vtag_d      = vtag_q;
      way_d       = way_q;
      ustate_d    = ustate_q;
      touch_d     = touch_q;
      op_d        = op_q;
      clr_d       = clr_q;
      snp_valid_c = 1'b0;
      snp_res_c   = SN_NOHIT;
      case (state_q)
         S_IDLE: if (bus_if.cmd_valid) begin
            cmd_d = bus_if.cmd_n;
            set_d = bus_if.cmd_addr[OFF_W+INDEX_W-1:OFF_W];
            tag_d = bus_if.cmd_addr[31:OFF_W+INDEX_W];
            clr_d = '0;
            case (bus_if.cmd_n)
               C_CLR:                                    state_d = S_CLEAR;
               C_RD, C_WR, C_IF, C_SRD, C_SRWIM, C_SINV: state_d = S_LOOKUP;
               default:                                  state_d = S_DONE;
            endcase
         end
         S_LOOKUP: state_d = S_EVAL;
         S_EVAL: begin
            way_d    = bus_if.lk_way;
            vtag_d   = bus_if.lk_vtag;
            ustate_d = bus_if.lk_state;
            touch_d  = 1'b0;
            op_d     = OP_WRITE;
            state_d  = S_DONE;
            case (cmd_q)
               C_RD, C_IF: begin
                  touch_d = 1'b1;
                  op_d    = OP_READ;
                  if (resident) state_d = S_UPDATE;
                  else begin
                     way_d   = bus_if.lk_vway;
                     state_d = (bus_if.lk_vstate == ST_M) ? S_EVICT : S_BUS;
                  end
               end
               C_WR: begin
                  touch_d  = 1'b1;
                  ustate_d = ST_M;
                  if (resident) begin
                     op_d    = OP_INVAL;
                     state_d = (bus_if.lk_state == ST_S) ? S_BUS : S_UPDATE;
                  end else begin
                     op_d    = OP_RWIM;
                     way_d   = bus_if.lk_vway;
                     state_d = (bus_if.lk_vstate == ST_M) ? S_EVICT : S_BUS;
                  end
               end
               C_SRD: begin
                  snp_valid_c = 1'b1;
                  ustate_d    = ST_S;
                  if (resident) begin
                     snp_res_c = (bus_if.lk_state == ST_M) ? SN_HITM : SN_HIT;
                     if (bus_if.lk_state == ST_M)      state_d = S_BUS;
                     else if (bus_if.lk_state == ST_E) state_d = S_UPDATE;
                  end
               end
               C_SRWIM: begin
                  snp_valid_c = 1'b1;
                  ustate_d    = ST_I;
                  if (resident) begin
                     snp_res_c = (bus_if.lk_state == ST_M) ? SN_HITM : SN_HIT;
                     state_d   = (bus_if.lk_state == ST_M) ? S_BUS : S_UPDATE;
                  end
               end
               C_SINV: begin
                  ustate_d = ST_I;
                  if (resident && bus_if.lk_state == ST_S) state_d = S_UPDATE;
               end
               default: state_d = S_DONE;
            endcase
         end
         S_EVICT: if (bus_if.bus_done) state_d = S_BUS;
         S_BUS: if (bus_if.bus_done) begin
            state_d = S_UPDATE;
            // fill state depends on whether any other cache kept a copy
            if (op_q == OP_READ) ustate_d = (bus_if.bus_snoop == SN_NOHIT) ? ST_E : ST_S;
         end
         S_UPDATE: state_d = S_DONE;
         S_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == INDEX_W'(SETS - 1)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cmd_q    <= '0;
         set_q    <= '0;
         tag_q    <= '0;
         vtag_q   <= '0;
         way_q    <= '0;
         ustate_q <= '0;
         touch_q  <= 1'b0;
         op_q     <= '0;
         clr_q    <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         set_q    <= set_d;
         tag_q    <= tag_d;
         vtag_q   <= vtag_d;
         way_q    <= way_d;
         ustate_q <= ustate_d;
         touch_q  <= touch_d;
         op_q     <= op_d;
         clr_q    <= clr_d;
      end
   end

   assign bus_if.cmd_ready  = (state_q == S_IDLE);
   assign bus_if.cmd_done   = (state_q == S_DONE);
   assign bus_if.lk_req     = (state_q == S_LOOKUP);
   assign bus_if.lk_set     = bus_if.lk_req ? set_q : '0;
   assign bus_if.lk_tag     = bus_if.lk_req ? tag_q : '0;
   assign bus_if.upd_valid  = (state_q == S_UPDATE);
   assign bus_if.upd_set    = bus_if.upd_valid ? set_q : '0;
   assign bus_if.upd_way    = bus_if.upd_valid ? way_q : '0;
   assign bus_if.upd_tag    = bus_if.upd_valid ? tag_q : '0;
   assign bus_if.upd_state  = bus_if.upd_valid ? ustate_q : '0;
   assign bus_if.upd_touch  = bus_if.upd_valid & touch_q;
   assign bus_if.clr_valid  = (state_q == S_CLEAR);
   assign bus_if.clr_set    = bus_if.clr_valid ? clr_q : '0;
   assign bus_if.bus_valid  = (state_q == S_EVICT) || (state_q == S_BUS);
   assign bus_if.bus_op     = (state_q == S_EVICT) ? OP_WRITE : (state_q == S_BUS) ? op_q : '0;
   assign bus_if.bus_addr   = (state_q == S_EVICT) ? {vtag_q, set_q, {OFF_W{1'b0}}} :
                              (state_q == S_BUS)   ? {tag_q,  set_q, {OFF_W{1'b0}}} : '0;
   assign bus_if.snp_valid  = snp_valid_c;
   assign bus_if.snp_result = snp_res_c;
endmodule

// File: tb/tb_llc_req_sequencer.sv
// Bench for llc_req_sequencer: directed table, randomized vectors against a
// rule-level model, clear sweep on a 16-set instance, and reset mid-bus.
module tb_llc_req_sequencer;
   typedef struct {
      logic [3:0]  n;     logic [31:0] addr;  logic        hit;   logic [2:0] way;
      logic [1:0]  st;    logic [2:0]  vway;  logic [1:0]  vst;   logic [11:0] vtag;
      logic [1:0]  snoop; int          lat;
      logic [13:0] e_set; logic [11:0] e_tag; int          nbus;
      logic [1:0]  op0;   logic [31:0] a0;    logic [1:0]  op1;   logic [31:0] a1;
      logic        upd;   logic [2:0]  uway;  logic [1:0]  ust;   logic        utouch;
      logic        snp;   logic [1:0]  sres;  int          done_cyc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   llc_req_sequencer_if #(.SETS(16384), .WAYS(8), .LINE_BYTES(64)) bif ();
   llc_req_sequencer_if #(.SETS(16),    .WAYS(8), .LINE_BYTES(64)) cif ();

   llc_req_sequencer #(.SETS(16384), .WAYS(8), .LINE_BYTES(64)) dut (.clk(clk), .rst(rst), .bus_if(bif));
   llc_req_sequencer #(.SETS(16),    .WAYS(8), .LINE_BYTES(64)) dut_clr (.clk(clk), .rst(rst), .bus_if(cif));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t tv(input logic [3:0] n, input logic [31:0] addr, input logic hit,
         input logic [2:0] way, input logic [1:0] st, input logic [2:0] vway, input logic [1:0] vst,
         input logic [11:0] vtag, input logic [1:0] snoop, input int lat, input logic [13:0] e_set,
         input logic [11:0] e_tag, input int nbus, input logic [1:0] op0, input logic [31:0] a0,
         input logic [1:0] op1, input logic [31:0] a1, input logic upd, input logic [2:0] uway,
         input logic [1:0] ust, input logic utouch, input logic snp, input logic [1:0] sres,
         input int done_cyc);
      vec_t v;
      v.n = n; v.addr = addr; v.hit = hit; v.way = way; v.st = st; v.vway = vway; v.vst = vst;
      v.vtag = vtag; v.snoop = snoop; v.lat = lat; v.e_set = e_set; v.e_tag = e_tag;
      v.nbus = nbus; v.op0 = op0; v.a0 = a0; v.op1 = op1; v.a1 = a1; v.upd = upd; v.uway = uway;
      v.ust = ust; v.utouch = utouch; v.snp = snp; v.sres = sres; v.done_cyc = done_cyc;
      return v;
   endfunction

   // Reference: list the bus ops, the final array write and the snoop reply
   // that the MESI rules call for, then derive completion time from them.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      logic [31:0] line = v.addr & ~32'h3F;
      logic [31:0] vict = (32'(v.vtag) << 20) | (((v.addr >> 6) % 16384) << 6);
      logic [1:0]  ops[$];
      logic [31:0] adr[$];
      bit          present = v.hit && (v.st != 2'd0);
      r.e_set = 14'((v.addr >> 6) % 16384);
      r.e_tag = 12'(v.addr >> 20);
      r.upd = 1'b0; r.uway = v.way; r.ust = 2'd0; r.utouch = 1'b0; r.snp = 1'b0; r.sres = 2'd0;
      case (v.n)
         4'd0, 4'd2: begin
            r.utouch = 1'b1; r.upd = 1'b1;
            if (present) r.ust = v.st;
            else begin
               if (v.vst == 2'd3) begin ops.push_back(2'd1); adr.push_back(vict); end
               ops.push_back(2'd0); adr.push_back(line);
               r.uway = v.vway; r.ust = (v.snoop == 2'd0) ? 2'd2 : 2'd1;
            end
         end
         4'd1: begin
            r.utouch = 1'b1; r.upd = 1'b1; r.ust = 2'd3;
            if (present) begin
               if (v.st == 2'd1) begin ops.push_back(2'd2); adr.push_back(line); end
            end else begin
               if (v.vst == 2'd3) begin ops.push_back(2'd1); adr.push_back(vict); end
               ops.push_back(2'd3); adr.push_back(line);
               r.uway = v.vway;
            end
         end
         4'd3, 4'd5: begin
            r.snp = 1'b1;
            if (present) begin
               r.sres = (v.st == 2'd3) ? 2'd2 : 2'd1;
               if (v.st == 2'd3) begin ops.push_back(2'd1); adr.push_back(line); end
               r.upd = (v.n == 4'd5) || (v.st != 2'd1);
               r.ust = (v.n == 4'd5) ? 2'd0 : 2'd1;
            end
         end
         4'd6: if (present && v.st == 2'd1) begin r.upd = 1'b1; r.ust = 2'd0; end
         default: ;
      endcase
      r.nbus = ops.size();
      r.op0 = 0; r.a0 = 0; r.op1 = 0; r.a1 = 0;
      if (ops.size() > 0) begin r.op0 = ops[0]; r.a0 = adr[0]; end
      if (ops.size() > 1) begin r.op1 = ops[1]; r.a1 = adr[1]; end
      if (v.n inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6})
         r.done_cyc = 3 + r.nbus * (v.lat + 1) + int'(r.upd);
      else
         r.done_cyc = 1;
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input string nm);
      int cyc = 0, nb = 0, nlk = 0, nupd = 0, nsnp = 0, ndone = 0, wcnt = 0, done_at = -1;
      logic [1:0]  ops[4];
      logic [31:0] adrs[4];
      logic [1:0]  cur_op = 0;
      logic [31:0] cur_addr = 0;
      logic [13:0] g_set = 0;
      logic [11:0] g_tag = 0, g_utag = 0;
      logic [2:0]  g_uway = 0;
      logic [1:0]  g_ust = 0, g_sres = 0;
      logic        g_utouch = 0;
      bit ready_bad = 0, stable_bad = 0;
      bit lk_exp = v.n inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
      @(negedge clk);
      chk({nm, " ready_idle"}, 32'(bif.cmd_ready), 1);
      bif.cmd_valid = 1'b1; bif.cmd_n = v.n; bif.cmd_addr = v.addr;
      bif.lk_hit = v.hit; bif.lk_way = v.way; bif.lk_state = v.st;
      bif.lk_vway = v.vway; bif.lk_vstate = v.vst; bif.lk_vtag = v.vtag;
      @(posedge clk);
      #1 bif.cmd_valid = 1'b0;
      while (ndone == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bif.bus_done = 1'b0;
         if (bif.cmd_ready) ready_bad = 1;
         if (bif.lk_req) begin nlk++; g_set = bif.lk_set; g_tag = bif.lk_tag; end
         if (bif.snp_valid) begin nsnp++; g_sres = bif.snp_result; end
         if (bif.upd_valid) begin
            nupd++; g_uway = bif.upd_way; g_ust = bif.upd_state;
            g_utouch = bif.upd_touch; g_utag = bif.upd_tag;
         end
         if (bif.bus_valid) begin
            if (wcnt == 0) begin
               cur_op = bif.bus_op; cur_addr = bif.bus_addr;
               if (nb < 4) begin ops[nb] = cur_op; adrs[nb] = cur_addr; end
               nb++;
            end else if (bif.bus_op !== cur_op || bif.bus_addr !== cur_addr) stable_bad = 1;
            if (wcnt == v.lat) begin
               bif.bus_done = 1'b1; bif.bus_snoop = v.snoop; wcnt = 0;
            end else wcnt++;
         end
         if (bif.cmd_done) begin ndone++; done_at = cyc; end
      end
      @(negedge clk);
      bif.bus_done = 1'b0;
      chk({nm, " ready_after"}, 32'(bif.cmd_ready), 1);
      chk({nm, " done_single"}, 32'(bif.cmd_done), 0);
      chk({nm, " n_lookup"}, nlk, lk_exp ? 1 : 0);
      if (lk_exp && nlk > 0) begin
         chk({nm, " lk_set"}, 32'(g_set), 32'(v.e_set));
         chk({nm, " lk_tag"}, 32'(g_tag), 32'(v.e_tag));
      end
      chk({nm, " n_bus"}, nb, v.nbus);
      if (v.nbus > 0 && nb > 0) begin
         chk({nm, " op0"}, 32'(ops[0]), 32'(v.op0));
         chk({nm, " addr0"}, adrs[0], v.a0);
      end
      if (v.nbus > 1 && nb > 1) begin
         chk({nm, " op1"}, 32'(ops[1]), 32'(v.op1));
         chk({nm, " addr1"}, adrs[1], v.a1);
      end
      chk({nm, " bus_stable"}, 32'(stable_bad), 0);
      chk({nm, " n_upd"}, nupd, int'(v.upd));
      if (v.upd && nupd > 0) begin
         chk({nm, " upd_way"}, 32'(g_uway), 32'(v.uway));
         chk({nm, " upd_state"}, 32'(g_ust), 32'(v.ust));
         chk({nm, " upd_touch"}, 32'(g_utouch), 32'(v.utouch));
         chk({nm, " upd_tag"}, 32'(g_utag), 32'(v.e_tag));
      end
      chk({nm, " n_snp"}, nsnp, int'(v.snp));
      if (v.snp && nsnp > 0) chk({nm, " snp_result"}, 32'(g_sres), 32'(v.sres));
      chk({nm, " n_done"}, ndone, 1);
      chk({nm, " done_cycle"}, done_at, v.done_cyc);
      chk({nm, " ready_low"}, 32'(ready_bad), 0);
      $display("txn %s cmd=%0d addr=%h bus_ops=%0d upd=%0d done_at=%0d", nm, v.n, v.addr, nb, nupd, done_at);
   endtask

   localparam logic [31:0] A  = 32'h1234_5678, LA = 32'h1234_5640;
   localparam logic [31:0] B  = 32'h8000_0047, LB = 32'h8000_0040;

   initial begin
      vec_t tbl[12];
      logic [3:0] codes[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
      int clr_n, clr_err, clr_first, clr_done, seen;
      bit rdy_bad;
      bif.cmd_valid = 0; bif.cmd_n = 0; bif.cmd_addr = 0; bif.lk_hit = 0; bif.lk_way = 0;
      bif.lk_state = 0; bif.lk_vway = 0; bif.lk_vstate = 0; bif.lk_vtag = 0;
      bif.bus_done = 0; bif.bus_snoop = 0;
      cif.cmd_valid = 0; cif.cmd_n = 0; cif.cmd_addr = 0; cif.lk_hit = 0; cif.lk_way = 0;
      cif.lk_state = 0; cif.lk_vway = 0; cif.lk_vstate = 0; cif.lk_vtag = 0;
      cif.bus_done = 0; cif.bus_snoop = 0;

      //            n  addr hit way st vway vst vtag     snp lat set      tag      nb op0 a0            op1 a1  upd way st tch snp res done
      tbl[0]  = tv(0, A, 0, 0, 0, 5, 0, 12'h3AB, 0, 2, 14'h1159, 12'h123, 1, 0, LA,           0, 0,  1, 5, 2, 1, 0, 0, 7);
      tbl[1]  = tv(0, A, 0, 0, 0, 2, 3, 12'h3AB, 1, 0, 14'h1159, 12'h123, 2, 1, 32'h3AB45640, 0, LA, 1, 2, 1, 1, 0, 0, 6);
      tbl[2]  = tv(1, A, 1, 3, 1, 0, 0, 12'h000, 0, 1, 14'h1159, 12'h123, 1, 2, LA,           0, 0,  1, 3, 3, 1, 0, 0, 6);
      tbl[3]  = tv(1, B, 1, 6, 2, 0, 0, 12'h000, 0, 0, 14'h0001, 12'h800, 0, 0, 0,            0, 0,  1, 6, 3, 1, 0, 0, 4);
      tbl[4]  = tv(3, A, 1, 1, 3, 0, 0, 12'h000, 0, 1, 14'h1159, 12'h123, 1, 1, LA,           0, 0,  1, 1, 1, 0, 1, 2, 6);
      tbl[5]  = tv(3, A, 0, 0, 0, 4, 3, 12'h055, 0, 0, 14'h1159, 12'h123, 0, 0, 0,            0, 0,  0, 0, 0, 0, 1, 0, 3);
      tbl[6]  = tv(4, A, 1, 2, 3, 0, 0, 12'h000, 0, 0, 14'h1159, 12'h123, 0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0, 1);
      tbl[7]  = tv(6, A, 1, 4, 1, 0, 0, 12'h000, 0, 0, 14'h1159, 12'h123, 0, 0, 0,            0, 0,  1, 4, 0, 0, 0, 0, 4);
      tbl[8]  = tv(2, B, 1, 7, 1, 3, 3, 12'hFFF, 0, 0, 14'h0001, 12'h800, 0, 0, 0,            0, 0,  1, 7, 1, 1, 0, 0, 4);
      tbl[9]  = tv(5, B, 1, 7, 2, 0, 0, 12'h000, 0, 0, 14'h0001, 12'h800, 0, 0, 0,            0, 0,  1, 7, 0, 0, 1, 1, 4);
      tbl[10] = tv(1, B, 0, 0, 0, 6, 3, 12'hABC, 2, 3, 14'h0001, 12'h800, 2, 1, 32'hABC00040, 3, LB, 1, 6, 3, 1, 0, 0, 12);
      tbl[11] = tv(5, A, 1, 0, 3, 0, 0, 12'h000, 0, 0, 14'h1159, 12'h123, 1, 1, LA,           0, 0,  1, 0, 0, 0, 1, 2, 5);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset cmd_ready", 32'(bif.cmd_ready), 1);
      chk("reset lk_req", 32'(bif.lk_req), 0);
      chk("reset upd_valid", 32'(bif.upd_valid), 0);
      chk("reset bus_valid", 32'(bif.bus_valid), 0);
      chk("reset bus_addr", bif.bus_addr, 0);
      chk("reset cmd_done", 32'(bif.cmd_done), 0);
      chk("reset snp_valid", 32'(bif.snp_valid), 0);
      chk("reset clr_valid", 32'(cif.clr_valid), 0);

      for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 40; i++) begin
         vec_t r;
         r.n = codes[$urandom_range(0, 8)];
         r.addr = $urandom;
         r.hit = 1'($urandom_range(0, 1));
         r.way = 3'($urandom_range(0, 7));
         r.st = r.hit ? 2'($urandom_range(1, 3)) : 2'd0;
         r.vway = 3'($urandom_range(0, 7));
         r.vst = 2'($urandom_range(0, 3));
         r.vtag = 12'($urandom);
         r.snoop = 2'($urandom_range(0, 2));
         r.lat = $urandom_range(0, 3);
         run_vec(model(r), $sformatf("rnd%0d", i));
      end

      // clear sweep on the 16-set instance
      @(negedge clk);
      chk("clear ready_idle", 32'(cif.cmd_ready), 1);
      cif.cmd_valid = 1'b1; cif.cmd_n = 4'd8; cif.cmd_addr = 32'h0;
      @(posedge clk);
      #1 cif.cmd_valid = 1'b0;
      clr_n = 0; clr_err = 0; clr_first = -1; clr_done = -1; rdy_bad = 0;
      for (int c = 1; c <= 40 && clr_done < 0; c++) begin
         @(negedge clk);
         if (cif.cmd_ready) rdy_bad = 1;
         if (cif.clr_valid) begin
            if (clr_first < 0) clr_first = c;
            if (32'(cif.clr_set) != 32'(c - 1)) clr_err++;
            clr_n++;
         end
         if (cif.cmd_done) clr_done = c;
      end
      chk("clear count", clr_n, 16);
      chk("clear first_cycle", clr_first, 1);
      chk("clear set_order", clr_err, 0);
      chk("clear done_cycle", clr_done, 17);
      chk("clear ready_low", 32'(rdy_bad), 0);
      @(negedge clk);
      chk("clear ready_after", 32'(cif.cmd_ready), 1);
      $display("txn clear sets=%0d done_at=%0d", clr_n, clr_done);

      // reset while a bus read is outstanding
      @(negedge clk);
      bif.cmd_valid = 1'b1; bif.cmd_n = 4'd0; bif.cmd_addr = A;
      bif.lk_hit = 0; bif.lk_vstate = 0; bif.lk_vway = 3'd1;
      @(posedge clk);
      #1 bif.cmd_valid = 1'b0;
      seen = 0; clr_done = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (bif.bus_valid) seen = 1;
      end
      chk("rstbus bus_seen", seen, 1);
      repeat (2) @(negedge clk);
      chk("rstbus held", 32'(bif.bus_valid), 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("rstbus bus_valid", 32'(bif.bus_valid), 0);
            chk("rstbus cmd_ready", 32'(bif.cmd_ready), 1);
         end
         if (bif.cmd_done) clr_done++;
      end
      chk("rstbus no_done", clr_done, 0);
      $display("txn reset_during_bus done_pulses=%0d", clr_done);
      run_vec(tbl[1], "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
